uart_tx_arb: RTL

Two-requester round-robin arbiter that shares a single `uart_tx` serializer. Each requester gets a one-byte holding register with a valid/ready handshake. The arbiter sequences one byte at a time into `uart_tx` via its `i_TX_DV`/`i_TX_Byte` inputs, tracks completion through `o_TX_Active`/`o_TX_Done`, and returns a per-requester done pulse. It sits between client logic (e.g. command responder, debug printer) and the existing `uart_tx`.

---
 rtl/uart_tx_arb.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets two byte producers share one uart_tx serializer.
// Each requester owns a one-byte holding register; frames are launched one at a time.
module uart_tx_arb #(
    parameter int unsigned g_IDLE_GAP = 0
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,

    input  logic       i_A_DV,
    input  logic [7:0] i_A_Byte,
    output logic       o_A_Ready,
    output logic       o_A_Done,

    input  logic       i_B_DV,
    input  logic [7:0] i_B_Byte,
    output logic       o_B_Ready,
    output logic       o_B_Done,

    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,

    output logic [1:0] o_Grant,
    output logic [1:0] o_Dbg_State
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_DONE = 2'd1,
        S_GAP       = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(g_IDLE_GAP);

    state_t     state_q, state_d;

    logic       pend_a_q, pend_a_d;
    logic [7:0] byte_a_q, byte_a_d;
    logic       pend_b_q, pend_b_d;
    logic [7:0] byte_b_q, byte_b_d;

    // Set when B was the last requester whose frame completed; reset value favours A.
    logic       last_b_q, last_b_d;
    logic [7:0] gap_q, gap_d;

    logic       tx_dv_q, tx_dv_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [1:0] grant_q, grant_d;
    logic       a_done_q, a_done_d;
    logic       b_done_q, b_done_d;

    logic       launch;
    logic       win_b;
    logic       finish;
    logic       accept_a;
    logic       accept_b;

    // Handshake: a byte transfers on any rising edge where X_DV and X_Ready are
    // both high; DV while Ready is low is ignored and never overwrites the held byte.
    assign accept_a = i_A_DV && !pend_a_q;
    assign accept_b = i_B_DV && !pend_b_q;

    assign launch = (state_q == S_IDLE) && (pend_a_q || pend_b_q) && !i_TX_Active;
    assign win_b  = pend_b_q && (!pend_a_q || !last_b_q);
    assign finish = (state_q == S_WAIT_DONE) && i_TX_Done;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            pend_a_q  <= 1'b0;
            byte_a_q  <= 8'h00;
            pend_b_q  <= 1'b0;
            byte_b_q  <= 8'h00;
            last_b_q  <= 1'b1;
            gap_q     <= 8'h00;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            grant_q   <= 2'b00;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_a_q  <= pend_a_d;
            byte_a_q  <= byte_a_d;
            pend_b_q  <= pend_b_d;
            byte_b_q  <= byte_b_d;
            last_b_q  <= last_b_d;
            gap_q     <= gap_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
            grant_q   <= grant_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (launch)        state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (i_TX_Done)     state_d = S_GAP;
            S_GAP:       if (gap_q == 8'h00) state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // GAP always lasts at least one cycle so uart_tx leaves its cleanup state
    // before it can see the next start pulse.
    always_comb begin
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        grant_d   = grant_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        last_b_d  = last_b_q;
        gap_d     = gap_q;

        if (launch) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = win_b ? byte_b_q : byte_a_q;
            grant_d   = win_b ? 2'b10 : 2'b01;
        end

        if (finish) begin
            a_done_d = grant_q[0];
            b_done_d = grant_q[1];
            last_b_d = grant_q[1];
            grant_d  = 2'b00;
            gap_d    = GAP_LOAD;
        end

        if ((state_q == S_GAP) && (gap_q != 8'h00)) begin
            gap_d = gap_q - 8'h01;
        end
    end

    always_comb begin
        pend_a_d = pend_a_q;
        byte_a_d = byte_a_q;
        pend_b_d = pend_b_q;
        byte_b_d = byte_b_q;

        if (launch && !win_b) pend_a_d = 1'b0;
        if (launch &&  win_b) pend_b_d = 1'b0;

        if (accept_a) begin
            pend_a_d = 1'b1;
            byte_a_d = i_A_Byte;
        end
        if (accept_b) begin
            pend_b_d = 1'b1;
            byte_b_d = i_B_Byte;
        end
    end

    assign o_A_Ready   = !pend_a_q;
    assign o_B_Ready   = !pend_b_q;
    assign o_A_Done    = a_done_q;
    assign o_B_Done    = b_done_q;
    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Grant     = grant_q;
    assign o_Dbg_State = state_q;

endmodule
